// File: rtl/keymap_pkg.sv
// Shared definitions for the keyboard key-mapping stage.
// Covers channel modes, repeat FSM states and PS/2 set-2 scan codes as {extend, code}.
package keymap_pkg;

    localparam int CODE_W = 9;

    localparam logic [1:0] MODE_LEVEL  = 2'd0;
    localparam logic [1:0] MODE_PULSE  = 2'd1;
    localparam logic [1:0] MODE_REPEAT = 2'd2;
    localparam logic [1:0] MODE_TOGGLE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RATE  = 2'd2
    } rpt_state_t;

    localparam logic [CODE_W-1:0] KEY_W     = 9'h01D;
    localparam logic [CODE_W-1:0] KEY_A     = 9'h01C;
    localparam logic [CODE_W-1:0] KEY_D     = 9'h023;
    localparam logic [CODE_W-1:0] KEY_ENTER = 9'h05A;
    localparam logic [CODE_W-1:0] KEY_UP    = 9'h175;
    localparam logic [CODE_W-1:0] KEY_DOWN  = 9'h172;
    localparam logic [CODE_W-1:0] KEY_LEFT  = 9'h16B;
    localparam logic [CODE_W-1:0] KEY_RIGHT = 9'h174;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keymap_channel_ctrl_if.sv
// Decoded keyboard event bus: one make/break event per valid cycle.
interface keymap_channel_ctrl_if;
    import keymap_pkg::*;

    logic              evt_valid;
    logic [CODE_W-1:0] evt_code;
    logic              evt_break;

    modport master (output evt_valid, output evt_code, output evt_break);
    modport slave  (input  evt_valid, input  evt_code, input  evt_break);
endinterface

// File: rtl/keymap_channel.sv
// One key-mapping channel: scan-code compare, held bit and the mode-specific output.
// Repeat mode runs an IDLE/DELAY/RATE countdown that emits the auto-repeat pulses.
module keymap_channel
    import keymap_pkg::*;
#(
    parameter logic [CODE_W-1:0] KEY_CODE  = KEY_W,
    parameter logic [1:0]        MODE      = MODE_LEVEL,
    parameter int                DELAY_CYC = 50_000_000,
    parameter int                RATE_CYC  = 10_000_000,
    parameter int                CNT_W     = $clog2(max_int(DELAY_CYC, RATE_CYC) + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              evt_valid,
    input  logic [CODE_W-1:0] evt_code,
    input  logic              evt_break,
    input  logic              flush,
    output logic              key_out,
    output logic              key_held,
    output logic              match
);

    // Loads are one less than the period because the pulse fires on the cycle the count is 0.
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(RATE_CYC - 1);

    logic             make_acc;
    logic             brk_acc;
    logic             rpt_pulse;
    logic             held_d;
    logic             out_d;
    rpt_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign match    = evt_valid && (evt_code == KEY_CODE) && !flush;
    assign make_acc = match && !evt_break && !key_held;
    assign brk_acc  = match &&  evt_break &&  key_held;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rpt_pulse = 1'b0;
        if (flush || brk_acc) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (make_acc && (MODE == MODE_REPEAT)) begin
                        rpt_pulse = 1'b1;
                        state_d   = ST_DELAY;
                        cnt_d     = DELAY_LOAD;
                    end
                end
                ST_DELAY, ST_RATE: begin
                    if (cnt_q == '0) begin
                        rpt_pulse = 1'b1;
                        state_d   = ST_RATE;
                        cnt_d     = RATE_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        held_d = key_held;
        out_d  = key_out;
        if (flush) begin
            held_d = 1'b0;
            out_d  = 1'b0;
        end else begin
            if (make_acc) begin
                held_d = 1'b1;
            end else if (brk_acc) begin
                held_d = 1'b0;
            end
            case (MODE)
                MODE_LEVEL:  out_d = held_d;
                MODE_PULSE:  out_d = make_acc;
                MODE_REPEAT: out_d = rpt_pulse;
                default:     out_d = key_out ^ make_acc;
            endcase
        end
    end

    // Registered outputs: every response appears the cycle after the event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            key_held <= 1'b0;
            key_out  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_held <= held_d;
            key_out  <= out_d;
        end
    end

endmodule

// File: rtl/keymap_channel_ctrl.sv
// Key-mapping stage between the PS/2 decoder and game logic: NUM_KEYS independent channels,
// each matching one configurable scan code and driving its output in its own mode.
module keymap_channel_ctrl
    import keymap_pkg::*;
#(
    parameter int                         NUM_KEYS  = 4,
    parameter logic [NUM_KEYS*CODE_W-1:0] KEY_CODES = {9'h05A, 9'h023, 9'h01C, 9'h01D},
    parameter logic [NUM_KEYS*2-1:0]      KEY_MODES = {2'd1, 2'd0, 2'd0, 2'd0},
    parameter int                         DELAY_CYC = 50_000_000,
    parameter int                         RATE_CYC  = 10_000_000,
    parameter int                         CNT_W     = $clog2(max_int(DELAY_CYC, RATE_CYC) + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    keymap_channel_ctrl_if.slave  evt,
    input  logic                  flush,
    output logic [NUM_KEYS-1:0]   key_out,
    output logic [NUM_KEYS-1:0]   key_held,
    output logic                  evt_hit
);

    logic [NUM_KEYS-1:0] match_bits;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        keymap_channel #(
            .KEY_CODE  (KEY_CODES[CODE_W*i +: CODE_W]),
            .MODE      (KEY_MODES[2*i +: 2]),
            .DELAY_CYC (DELAY_CYC),
            .RATE_CYC  (RATE_CYC),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .evt_valid (evt.evt_valid),
            .evt_code  (evt.evt_code),
            .evt_break (evt.evt_break),
            .flush     (flush),
            .key_out   (key_out[i]),
            .key_held  (key_held[i]),
            .match     (match_bits[i])
        );
    end

    // Match bits are already masked by flush, so a discarded event never reports a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_hit <= 1'b0;
        end else begin
            evt_hit <= |match_bits;
        end
    end

endmodule

// File: tb/tb_keymap_channel_ctrl.sv
// Randomised scoreboard bench for keymap_channel_ctrl against a per-key reference model.
module tb_keymap_channel_ctrl;
    import keymap_pkg::*;

    localparam int D = 5;
    localparam int R = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] key_out;
    logic [3:0] key_held;
    logic       evt_hit;

    keymap_channel_ctrl_if evt_if ();

    keymap_channel_ctrl #(
        .NUM_KEYS  (4),
        .KEY_CODES ({9'h05A, 9'h023, 9'h01C, 9'h01D}),
        .KEY_MODES ({2'd3, 2'd2, 2'd1, 2'd0}),
        .DELAY_CYC (D),
        .RATE_CYC  (R)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .evt      (evt_if),
        .flush    (flush),
        .key_out  (key_out),
        .key_held (key_held),
        .evt_hit  (evt_hit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] out;
        logic [3:0] held;
        logic       hit;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: per-key held flag, toggle latch and time of the accepted press.
    logic [8:0] code_of [4] = '{9'h01D, 9'h01C, 9'h023, 9'h05A};
    int         mode_of [4] = '{0, 1, 2, 3};
    bit         m_held  [4];
    bit         m_tog   [4];
    int         m_mt    [4];
    int         cyc = 0;

    // Auto-repeat pulses fall at press age 0, D, D+R, D+2R, ...
    function automatic bit rpt_due(input int age);
        return (age == 0) || (age >= D && ((age - D) % R) == 0);
    endfunction

    task automatic step(input bit v, input logic [8:0] c, input bit b, input bit f, input bit r);
        exp_t e;
        bit   match, mk, br;
        @(negedge clk);
        rst_n            = r;
        evt_if.evt_valid = v;
        evt_if.evt_code  = c;
        evt_if.evt_break = b;
        flush            = f;
        e = '0;
        if (!r || f) begin
            for (int i = 0; i < 4; i++) begin
                m_held[i] = 1'b0;
                m_tog[i]  = 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                match = v && (c == code_of[i]);
                mk    = match && !b && !m_held[i];
                br    = match &&  b &&  m_held[i];
                if (match) e.hit = 1'b1;
                if (mk) begin
                    m_held[i] = 1'b1;
                    m_mt[i]   = cyc;
                    if (mode_of[i] == 3) m_tog[i] = !m_tog[i];
                end
                if (br) m_held[i] = 1'b0;
                case (mode_of[i])
                    0:       e.out[i] = m_held[i];
                    1:       e.out[i] = mk;
                    2:       e.out[i] = m_held[i] && rpt_due(cyc - m_mt[i]);
                    default: e.out[i] = m_tog[i];
                endcase
                e.held[i] = m_held[i];
            end
        end
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic ev(input logic [8:0] c, input bit b);
        step(1'b1, c, b, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({key_out, key_held, evt_hit} !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: key_out=%b key_held=%b evt_hit=%b, expected key_out=%b key_held=%b evt_hit=%b",
                             $time, key_out, key_held, evt_hit, e.out, e.held, e.hit);
                end
            end
        end
    end

    initial begin : driver
        logic [8:0] c;
        int         sel;
        evt_if.evt_valid = 1'b0;
        evt_if.evt_code  = '0;
        evt_if.evt_break = 1'b0;

        repeat (3) step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Level and pulse channels, including a repeated make while held.
        ev(KEY_W, 1'b0); idle(3); ev(KEY_W, 1'b1); idle(2);
        ev(KEY_A, 1'b0); idle(3); ev(KEY_A, 1'b0); idle(2); ev(KEY_A, 1'b1); idle(2);

        // Repeat: long hold, then break coincident with the first delayed pulse, then re-press.
        ev(KEY_D, 1'b0); idle(19); ev(KEY_D, 1'b1); idle(5);
        ev(KEY_D, 1'b0); idle(4); ev(KEY_D, 1'b1); idle(4);
        ev(KEY_D, 1'b0); idle(6); ev(KEY_D, 1'b1); idle(3);

        // Toggle twice, press again, then flush coincident with a make.
        ev(KEY_ENTER, 1'b0); idle(1); ev(KEY_ENTER, 1'b1); idle(1);
        ev(KEY_ENTER, 1'b0); idle(1); ev(KEY_ENTER, 1'b1); idle(1);
        ev(KEY_ENTER, 1'b0); idle(2);
        ev(KEY_W, 1'b0);
        step(1'b1, KEY_ENTER, 1'b0, 1'b1, 1'b1); idle(2);
        ev(KEY_W, 1'b1); idle(1);

        // Extended code that must not alias, and a break for a key that is not held.
        ev(9'h11D, 1'b0); idle(1); ev(KEY_W, 1'b1); idle(2);

        // Asynchronous reset with ch0 held, observed before the next clock edge.
        ev(KEY_W, 1'b0); ev(KEY_D, 1'b0); idle(7);
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (key_out !== 4'b0000 || key_held !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: key_out=%b key_held=%b, expected 0000 0000", key_out, key_held);
        end
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
        idle(3);
        ev(KEY_D, 1'b0); idle(10); ev(KEY_D, 1'b1); idle(2);

        // Random traffic mixing known, extended and arbitrary codes with rare flush and reset.
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 5);
            if (sel < 4)       c = code_of[sel];
            else if (sel == 4) c = 9'h11D;
            else               c = 9'($urandom);
            step(($urandom_range(0, 3) == 0), c, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 199) == 0), ($urandom_range(0, 499) != 0));
        end
        idle(2);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
